// File: rtl/fxp2float_flex_pipe.sv
// rtl/fxp2float_flex_pipe.sv - streaming signed fixed-point to custom float converter
// Stages: sign/magnitude, leading-one normalise, round/pack/flag; a stage stalls only when full and blocked.
module fxp2float_flex_pipe #(
  parameter int WII   = 16,
  parameter int WIF   = 16,
  parameter int EW    = 8,
  parameter int MW    = 23,
  parameter int ROUND = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WII+WIF-1:0] in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EW+MW:0]     out,
  output logic               overflow,
  output logic               underflow
);
  localparam int NI   = WII + WIF;
  localparam int PW   = (NI > 1) ? $clog2(NI) : 1;
  localparam int XW   = NI + MW + 2;
  localparam int BIAS = (1 << (EW - 1)) - 1;
  localparam int EMAX = (1 << EW) - 1;

  logic           s1_v_q, s1_v_d, s1_sign_q, s1_sign_d;
  logic [NI-1:0]  s1_mag_q, s1_mag_d;
  logic           s2_v_q, s2_v_d, s2_sign_q, s2_sign_d, s2_zero_q, s2_zero_d;
  logic [NI-1:0]  s2_norm_q, s2_norm_d;
  logic [PW-1:0]  s2_p_q, s2_p_d;
  logic           s3_v_q, s3_v_d, s3_ovf_q, s3_ovf_d, s3_unf_q, s3_unf_d;
  logic [EW+MW:0] s3_out_q, s3_out_d;

  logic               en1, en2, en3;
  logic [PW-1:0]      lead_p;
  logic [XW-2:0]      ext;
  logic [MW-1:0]      mant;
  logic               guard, sticky, inc;
  logic [MW:0]        mant_r;
  logic signed [31:0] exp_b, exp_r;

  always_comb begin
    en3 = ~s3_v_q | out_ready;
    en2 = ~s2_v_q | en3;
    en1 = ~s1_v_q | en2;
  end

  assign in_ready  = en1;
  assign out_valid = s3_v_q;
  assign out       = s3_out_q;
  assign overflow  = s3_ovf_q;
  assign underflow = s3_unf_q;

  // Most negative input negates to 2^(NI-1), which still fits the unsigned magnitude.
  always_comb begin
    s1_v_d    = s1_v_q;
    s1_sign_d = s1_sign_q;
    s1_mag_d  = s1_mag_q;
    if (en1) begin
      s1_v_d    = in_valid;
      s1_sign_d = in[NI-1];
      s1_mag_d  = in[NI-1] ? -in : in;
    end
  end

  always_comb begin
    lead_p = '0;
    for (int i = 0; i < NI; i++) begin
      if (s1_mag_q[i]) lead_p = PW'(i);
    end
    s2_v_d    = s2_v_q;
    s2_sign_d = s2_sign_q;
    s2_zero_d = s2_zero_q;
    s2_p_d    = s2_p_q;
    s2_norm_d = s2_norm_q;
    if (en2) begin
      s2_v_d    = s1_v_q;
      s2_sign_d = s1_sign_q;
      s2_zero_d = ~|s1_mag_q;
      s2_p_d    = lead_p;
      s2_norm_d = s1_mag_q << (PW'(NI - 1) - lead_p);
    end
  end

  // Hidden bit drops off the top of ext; padding keeps guard/sticky defined when MW >= NI.
  always_comb begin
    ext    = (XW - 1)'({s2_norm_q, {(MW + 2){1'b0}}});
    mant   = ext[XW-2 -: MW];
    guard  = ext[XW-2-MW];
    sticky = |ext[XW-3-MW:0];
    inc    = (ROUND != 0) && guard && (sticky || mant[0]);
    mant_r = {1'b0, mant} + (MW + 1)'(inc);
    exp_b  = 32'(s2_p_q);
    exp_b  = exp_b - WIF + BIAS;
    exp_r  = exp_b + 32'(mant_r[MW]);

    s3_v_d   = s3_v_q;
    s3_out_d = s3_out_q;
    s3_ovf_d = s3_ovf_q;
    s3_unf_d = s3_unf_q;
    if (en3) begin
      s3_v_d   = s2_v_q;
      s3_ovf_d = 1'b0;
      s3_unf_d = 1'b0;
      if (s2_zero_q) begin
        s3_out_d = '0;
      end else if (exp_r >= EMAX) begin
        s3_out_d = {s2_sign_q, {EW{1'b1}}, {MW{1'b0}}};
        s3_ovf_d = 1'b1;
      end else if (exp_r <= 0) begin
        s3_out_d = {s2_sign_q, {(EW + MW){1'b0}}};
        s3_unf_d = 1'b1;
      end else begin
        s3_out_d = {s2_sign_q, exp_r[EW-1:0], mant_r[MW-1:0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_v_q    <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_mag_q  <= '0;
      s2_v_q    <= 1'b0;
      s2_sign_q <= 1'b0;
      s2_zero_q <= 1'b0;
      s2_p_q    <= '0;
      s2_norm_q <= '0;
      s3_v_q    <= 1'b0;
      s3_out_q  <= '0;
      s3_ovf_q  <= 1'b0;
      s3_unf_q  <= 1'b0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_sign_q <= s1_sign_d;
      s1_mag_q  <= s1_mag_d;
      s2_v_q    <= s2_v_d;
      s2_sign_q <= s2_sign_d;
      s2_zero_q <= s2_zero_d;
      s2_p_q    <= s2_p_d;
      s2_norm_q <= s2_norm_d;
      s3_v_q    <= s3_v_d;
      s3_out_q  <= s3_out_d;
      s3_ovf_q  <= s3_ovf_d;
      s3_unf_q  <= s3_unf_d;
    end
  end

endmodule

// File: tb/tb_fxp2float_flex_pipe.sv
// tb/tb_fxp2float_flex_pipe.sv - directed and streaming checks of fxp2float_flex_pipe
// Three instances: float32 RNE, float32 truncate, and a 20.16 -> half-precision format.
module tb_fxp2float_flex_pipe;
  localparam int N_RND = 10000;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, ovf_a, unf_a;
  logic [31:0] in_a, out_a;
  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, ovf_b, unf_b;
  logic [31:0] in_b, out_b;
  logic        in_valid_c, in_ready_c, out_valid_c, out_ready_c, ovf_c, unf_c;
  logic [35:0] in_c;
  logic [15:0] out_c;

  logic [31:0] bp_vec [5] = '{32'h00010000, 32'hFFFF0000, 32'h00000001, 32'h80000000, 32'h00030000};
  logic [31:0] sb [$];
  logic [31:0] x;
  int idx, oidx, first, last, acc, sent, rcvd, cyc;

  fxp2float_flex_pipe dut_a (
    .clk(clk), .rstn(rstn), .in_valid(in_valid_a), .in_ready(in_ready_a), .in(in_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out(out_a), .overflow(ovf_a), .underflow(unf_a)
  );

  fxp2float_flex_pipe #(.ROUND(0)) dut_b (
    .clk(clk), .rstn(rstn), .in_valid(in_valid_b), .in_ready(in_ready_b), .in(in_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out(out_b), .overflow(ovf_b), .underflow(unf_b)
  );

  fxp2float_flex_pipe #(.WII(20), .WIF(16), .EW(5), .MW(10)) dut_c (
    .clk(clk), .rstn(rstn), .in_valid(in_valid_c), .in_ready(in_ready_c), .in(in_c),
    .out_valid(out_valid_c), .out_ready(out_ready_c), .out(out_c), .overflow(ovf_c), .underflow(unf_c)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Q16.16 -> float32 through the simulator's double, then RNE down to 23 bits.
  function automatic logic [31:0] f32_model(input logic [31:0] v);
    logic [63:0] b;
    logic [22:0] m;
    logic [23:0] mr;
    logic        g, st;
    int          e;
    if (v == 32'h0) return 32'h0;
    b  = $realtobits($itor($signed(v)) / 65536.0);
    m  = b[51:29];
    g  = b[28];
    st = |b[27:0];
    mr = {1'b0, m} + 24'(g & (st | m[0]));
    e  = int'(b[62:52]) - 1023 + 127 + int'(mr[23]);
    return {b[63], e[7:0], mr[22:0]};
  endfunction

  task automatic conv_a(input string tag, input logic [31:0] v, input logic [31:0] exp_o);
    int lat;
    lat = 0;
    in_a = v;
    in_valid_a = 1'b1;
    out_ready_a = 1'b1;
    @(negedge clk);
    check_eq({tag, "_rdy"}, 64'(in_ready_a), 64'd1);
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    while (!out_valid_a && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'd2);
    check_eq(tag, 64'({ovf_a, unf_a, out_a}), 64'({2'b00, exp_o}));
  endtask

  task automatic conv_b(input string tag, input logic [31:0] v, input logic [31:0] exp_o);
    in_b = v;
    in_valid_b = 1'b1;
    @(negedge clk);
    check_eq({tag, "_rdy"}, 64'(in_ready_b), 64'd1);
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq(tag, 64'({out_valid_b, ovf_b, unf_b, out_b}), 64'({3'b100, exp_o}));
  endtask

  task automatic conv_c(input string tag, input logic [35:0] v, input logic [15:0] exp_o,
                        input logic exp_ovf, input logic exp_unf);
    in_c = v;
    in_valid_c = 1'b1;
    @(negedge clk);
    check_eq({tag, "_rdy"}, 64'(in_ready_c), 64'd1);
    @(posedge clk); #1;
    in_valid_c = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq(tag, 64'({out_valid_c, ovf_c, unf_c, out_c}), 64'({1'b1, exp_ovf, exp_unf, exp_o}));
  endtask

  initial begin
    rstn = 1'b0;
    in_valid_a = 1'b0; in_a = '0; out_ready_a = 1'b0;
    in_valid_b = 1'b0; in_b = '0; out_ready_b = 1'b1;
    in_valid_c = 1'b0; in_c = '0; out_ready_c = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    check_eq("rst_ov", 64'(out_valid_a), 64'd0);
    check_eq("rst_out", 64'({ovf_a, unf_a, out_a}), 64'd0);
    check_eq("rst_rdy", 64'(in_ready_a), 64'd1);

    conv_a("one",      32'h00010000, 32'h3F800000);
    conv_a("neg_one",  32'hFFFF0000, 32'hBF800000);
    conv_a("zero",     32'h00000000, 32'h00000000);
    conv_a("most_neg", 32'h80000000, 32'hC7000000);
    conv_a("lsb",      32'h00000001, 32'h37800000);
    conv_a("max_rne",  32'h7FFFFFFF, 32'h47000000);
    conv_a("tie_even", 32'h01000001, 32'h43800000);
    conv_a("tie_odd",  32'h01000003, 32'h43800002);

    conv_b("max_trunc", 32'h7FFFFFFF, 32'h46FFFFFF);
    conv_b("odd_trunc", 32'h01000003, 32'h43800001);
    conv_b("one_trunc", 32'h00010000, 32'h3F800000);

    conv_c("h_ovf",  36'h7FFFF0000, 16'h7C00, 1'b1, 1'b0);
    conv_c("h_unf",  36'h000000001, 16'h0000, 1'b0, 1'b1);
    conv_c("h_one",  36'h000010000, 16'h3C00, 1'b0, 1'b0);
    conv_c("h_nunf", 36'hFFFFFFFFF, 16'h8000, 1'b0, 1'b1);

    // Backpressure: three samples fill the pipe, then all five drain back-to-back.
    @(posedge clk); #1;
    idx = 0;
    out_ready_a = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid_a = (idx < 5);
      in_a = bp_vec[(idx < 5) ? idx : 0];
      @(negedge clk);
      if (in_valid_a && in_ready_a) idx++;
      @(posedge clk); #1;
    end
    check_eq("bp_acc", 64'(idx), 64'd3);
    check_eq("bp_stall", 64'(in_ready_a), 64'd0);
    out_ready_a = 1'b1;
    oidx = 0; first = -1; last = -1;
    for (int c = 0; c < 20 && oidx < 5; c++) begin
      in_valid_a = (idx < 5);
      in_a = bp_vec[(idx < 5) ? idx : 0];
      @(negedge clk);
      if (in_valid_a && in_ready_a) idx++;
      if (out_valid_a) begin
        check_eq($sformatf("bp_out%0d", oidx), 64'(out_a), 64'(f32_model(bp_vec[oidx])));
        if (first < 0) first = c;
        last = c;
        oidx++;
      end
      @(posedge clk); #1;
    end
    in_valid_a = 1'b0;
    check_eq("bp_n", 64'(oidx), 64'd5);
    check_eq("bp_span", 64'(last - first), 64'd4);
    @(posedge clk); #1;

    // Random bubbles on both sides against the real-arithmetic model.
    sent = 0; rcvd = 0; cyc = 0;
    while (rcvd < N_RND && cyc < 60000) begin
      x = $urandom() >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) x = -x;
      if ($urandom_range(0, 15) == 0) x = '0;
      in_a = x;
      in_valid_a = (sent < N_RND) && ($urandom_range(0, 9) < 7);
      out_ready_a = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      if (in_valid_a && in_ready_a) begin
        sb.push_back(f32_model(in_a));
        sent++;
      end
      if (out_valid_a && out_ready_a) begin
        check_eq("rnd_q", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) check_eq("rnd", 64'({ovf_a, unf_a, out_a}), 64'({2'b00, sb.pop_front()}));
        rcvd++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid_a = 1'b0;
    check_eq("rnd_sent", 64'(sent), 64'(N_RND));
    check_eq("rnd_rcvd", 64'(rcvd), 64'(N_RND));
    check_eq("rnd_left", 64'(sb.size()), 64'd0);

    // Mid-stream reset discards the three in-flight samples.
    out_ready_a = 1'b0;
    in_a = 32'h00020000;
    in_valid_a = 1'b1;
    acc = 0;
    for (int c = 0; c < 6 && acc < 3; c++) begin
      @(negedge clk);
      if (in_ready_a) acc++;
      @(posedge clk); #1;
    end
    in_valid_a = 1'b0;
    check_eq("rs_fill", 64'(acc), 64'd3);
    check_eq("rs_full", 64'(out_valid_a), 64'd1);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    check_eq("rs_ov0", 64'(out_valid_a), 64'd0);
    check_eq("rs_rdy", 64'(in_ready_a), 64'd1);
    @(posedge clk); #1;
    check_eq("rs_ov1", 64'(out_valid_a), 64'd0);
    conv_a("rs_fresh", 32'h00018000, 32'h3FC00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
